// File: rtl/seg7_scan_driver.sv
// Scans a double-buffered hex value onto a common-anode 8-digit 7-seg display (SEG/AN active-low).
// Latency: outputs are registered one cycle behind digit_idx/shadow; captured values appear at the next frame start.
// Backpressure: none, value_valid is always accepted (last strobe before commit wins); SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_driver #(
    parameter int BITWIDTH  = 8,
    parameter int N_DISPLAY = 2,
    parameter int SCAN_DIV  = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BITWIDTH-1:0]  value_in,
    input  logic                 value_valid,
    input  logic [N_DISPLAY-1:0] dp_in,
    output logic [7:0]           SEG,
    output logic [7:0]           AN,
    output logic                 pending,
    output logic                 frame_start
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(N_DISPLAY - 1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [2:0]          digit_idx_q, digit_idx_d;
    logic [BITWIDTH-1:0] shadow_q, shadow_d;
    logic [BITWIDTH-1:0] pend_reg_q, pend_reg_d;
    logic                pending_q, pending_d;
    logic [7:0]          seg_q, seg_d;
    logic [7:0]          an_q, an_d;
    logic                frame_start_q, frame_start_d;

    logic                term_cnt;
    logic                commit;
    logic [31:0]         nib_all;
    logic [3:0]          nib;
    logic [7:0]          dp_all;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Divider, frame commit and capture into the pending buffer.
    always_comb begin
        term_cnt    = (div_cnt_q == DIV_LAST);
        commit      = term_cnt && (digit_idx_q == IDX_LAST);
        div_cnt_d   = term_cnt ? '0 : div_cnt_q + DIV_W'(1);
        digit_idx_d = digit_idx_q;
        if (term_cnt) begin
            digit_idx_d = (digit_idx_q == IDX_LAST) ? 3'd0 : digit_idx_q + 3'd1;
        end
        shadow_d   = shadow_q;
        pend_reg_d = pend_reg_q;
        pending_d  = pending_q;
        if (commit) begin
            // A strobe landing on the commit edge is the newest value, so it bypasses the buffer.
            if (value_valid) begin
                shadow_d = value_in;
            end else if (pending_q) begin
                shadow_d = pend_reg_q;
            end
            pending_d = 1'b0;
        end else if (value_valid) begin
            pend_reg_d = value_in;
            pending_d  = 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] zero_from;
    logic       zero_run;

    // zero_from[i]: nibble i and every higher displayed nibble are zero.
    always_comb begin
        zero_from = '1;
        zero_run  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < N_DISPLAY) begin
                zero_run     = zero_run && (nib_all[4*i +: 4] == 4'd0);
                zero_from[i] = zero_run;
            end
        end
    end
`endif

    always_comb begin
        nib_all = 32'(shadow_q);
        nib     = nib_all[{digit_idx_q, 2'b00} +: 4];
        dp_all  = 8'(dp_in);
        seg_d   = {~dp_all[digit_idx_q], glyph(nib)};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((digit_idx_q != 3'd0) && zero_from[digit_idx_q]) begin
            seg_d = 8'hFF;
        end
`endif
        an_d          = ~(8'b1 << digit_idx_q);
        frame_start_d = (digit_idx_q == 3'd0) && (div_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            digit_idx_q   <= '0;
            shadow_q      <= '0;
            pend_reg_q    <= '0;
            pending_q     <= 1'b0;
            seg_q         <= 8'hFF;
            an_q          <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            pend_reg_q    <= pend_reg_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign SEG         = seg_q;
    assign AN          = an_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with BITWIDTH=8, N_DISPLAY=2, SCAN_DIV=2 (commit on every 4th edge).
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [7:0] value_in;
    logic       value_valid;
    logic [1:0] dp_in;
    logic [7:0] seg;
    logic [7:0] an;
    logic       pending;
    logic       frame_start;

    int tests_run;
    int tests_failed;
    int k;

    seg7_scan_driver #(
        .BITWIDTH (8),
        .N_DISPLAY(2),
        .SCAN_DIV (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .value_valid(value_valid),
        .dp_in      (dp_in),
        .SEG        (seg),
        .AN         (an),
        .pending    (pending),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic strobe(input logic [7:0] v);
        value_in    = v;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        k            = 0;
        rst_n        = 1'b0;
        value_in     = 8'h00;
        value_valid  = 1'b0;
        dp_in        = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_seg", seg, 8'hFF);
        check_eq("rst_an", an, 8'hFF);
        check_eq("rst_pending", {7'd0, pending}, 8'h00);
        check_eq("rst_fs", {7'd0, frame_start}, 8'h00);
        rst_n = 1'b1;

        // Idle scan: digit0 for 2 cycles, digit1 for 2 cycles.
        for (int i = 1; i <= 8; i++) begin
            step();
            check_eq($sformatf("idle_an_k%0d", k), an, ((k % 4) == 1 || (k % 4) == 2) ? 8'hFE : 8'hFD);
            check_eq($sformatf("idle_seg_k%0d", k), seg, 8'hC0);
            check_eq($sformatf("idle_fs_k%0d", k), {7'd0, frame_start}, ((k % 4) == 1) ? 8'h01 : 8'h00);
        end

        // Mid-frame capture of 3A, committed at edge 12.
        run_to(9);
        strobe(8'h3A);
        check_eq("cap_pending_k10", {7'd0, pending}, 8'h01);
        step();
        check_eq("cap_pending_k11", {7'd0, pending}, 8'h01);
        step();
        check_eq("cap_pending_k12", {7'd0, pending}, 8'h00);
        run_to(13);
        check_eq("v3a_an0", an, 8'hFE);
        check_eq("v3a_seg0", seg, 8'h88);
        run_to(15);
        check_eq("v3a_an1", an, 8'hFD);
        check_eq("v3a_seg1", seg, 8'hB0);

        // Last strobe wins: 11 is overwritten by 5F.
        run_to(17);
        strobe(8'h11);
        strobe(8'h5F);
        check_eq("ovw_pending_k19", {7'd0, pending}, 8'h01);
        step();
        check_eq("ovw_pending_k20", {7'd0, pending}, 8'h00);
        run_to(21);
        check_eq("v5f_seg0", seg, 8'h8E);
        run_to(23);
        check_eq("v5f_seg1", seg, 8'h92);

        // Strobe on the commit edge bypasses into the display.
        strobe(8'h07);
        check_eq("byp_pending_k24", {7'd0, pending}, 8'h00);
        step();
        check_eq("byp_pending_k25", {7'd0, pending}, 8'h00);
        check_eq("v07_seg0", seg, 8'hF8);
        run_to(27);
        check_eq("v07_seg1", seg, 8'hC0);

        // Zero value with decimal point on digit 1.
        dp_in = 2'b10;
        strobe(8'h00);
        run_to(29);
        check_eq("dp_seg0", seg, 8'hC0);
        run_to(31);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check_eq("dp_seg1", seg, 8'hFF);
`else
        check_eq("dp_seg1", seg, 8'h40);
`endif

        // Asynchronous reset with a value still pending.
        dp_in = 2'b00;
        run_to(32);
        strobe(8'h99);
        check_eq("pre_rst_pending", {7'd0, pending}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_seg", seg, 8'hFF);
        check_eq("arst_an", an, 8'hFF);
        check_eq("arst_pending", {7'd0, pending}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        step();
        check_eq("post_an0", an, 8'hFE);
        check_eq("post_seg0", seg, 8'hC0);
        check_eq("post_fs", {7'd0, frame_start}, 8'h01);
        check_eq("post_pending", {7'd0, pending}, 8'h00);
        run_to(3);
        check_eq("post_an1", an, 8'hFD);
        check_eq("post_seg1", seg, 8'hC0);
        run_to(5);
        check_eq("post_commit_seg0", seg, 8'hC0);
        check_eq("post_commit_pending", {7'd0, pending}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the calculator datapath.
- Consumes the computed sum and its valid strobe, and time-multiplexes it as hex digits onto the board's common-anode 8-digit seven-segment display (SEG/AN, active-low).
- New values are double-buffered and committed only at a scan-frame boundary, so a digit never shows half of an update.

Parameters:
- BITWIDTH, 8, width of value_in; shown as ceil(BITWIDTH/4) hex nibbles.
- N_DISPLAY, 2, number of scanned digits (1..8); digit i shows nibble i; nibbles beyond BITWIDTH show 0.
- SCAN_DIV, 100000, clock cycles each digit stays enabled (>=1); 100000 gives 1 ms per digit at 100 MHz.

Ports:
- clk  in  1  system clock (CLK100MHZ)
- rst_n  in  1  asynchronous, active-low reset
- value_in  in  BITWIDTH  value to display (calculator sum_value)
- value_valid  in  1  one-cycle strobe; captures value_in
- dp_in  in  N_DISPLAY  decimal-point enable per digit, active-high
- SEG  out  8  SEG[0]=CA..SEG[6]=CG, SEG[7]=DP; active-low
- AN  out  8  digit enables, active-low; AN[i] for digit i
- pending  out  1  high while a captured value awaits commit
- frame_start  out  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Reset (async assert, sync release): SEG=8'hFF, AN=8'hFF, pending=0, frame_start=0.
  - Also cleared on reset: div_cnt=0, digit_idx=0, shadow=0, pend_reg=0.
- Divider:
  - div_cnt increments every cycle.
  - At div_cnt==SCAN_DIV-1: div_cnt<=0 and digit_idx<=(digit_idx==N_DISPLAY-1)?0:digit_idx+1.
  - Each digit is therefore active for exactly SCAN_DIV cycles.
- Commit edge = the edge on which digit_idx wraps N_DISPLAY-1 -> 0.
  - At a commit edge, shadow<=pend_reg if pending=1, then pending<=0.
- Capture:
  - value_valid=1 on a non-commit edge: pend_reg<=value_in, pending<=1.
  - A later strobe before commit overwrites pend_reg; last value wins.
- Simultaneous value_valid and commit edge: value_in bypasses directly into shadow, pending<=0; any older pend_reg content is discarded.
- Outputs are registered, one cycle behind digit_idx/shadow:
  - AN = ~(8'b1 << digit_idx); AN[7:N_DISPLAY] are always 1.
  - SEG[6:0] = active-low hex glyph of nibble digit_idx of shadow.
    - Glyphs (full SEG, DP off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - SEG[7] = ~dp_in[digit_idx].
  - First cycle after reset release: AN=8'hFE, SEG=C0 (when dp_in=0).
- frame_start is registered; it is 1 in the cycle AN first shows digit 0 of a new frame, including the first frame after reset.
- SCAN_DIV=1: the digit advances every cycle; every Nth edge is a commit edge.
- N_DISPLAY=1: every divider terminal count is a commit edge; AN stays 8'hFE.
- Reset mid-frame: immediate return to reset values; pend_reg is lost.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: any digit i>0 whose nibble and all higher displayed nibbles of shadow are zero outputs SEG=8'hFF, DP included.
  - AN timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all N_DISPLAY digits always show their glyph, with leading zeros.

Test Plan:
1. Config BITWIDTH=8, N_DISPLAY=2, SCAN_DIV=2. Reset, release, no strobe -> AN alternates FE,FE,FD,FD,...; SEG=C0 throughout; frame_start pulses every 4 cycles.
2. Strobe value_in=8'h3A mid-frame -> pending=1 until the next commit edge. Then AN=FE gives SEG=88 and AN=FD gives SEG=B0; pending=0.
3. Strobe 8'h11 then 8'h5F before commit -> after commit, digit0 SEG=8E and digit1 SEG=92; 8'h11 is never displayed.
4. Strobe 8'h07 exactly on a commit edge -> the following frame shows digit0 SEG=F8 and digit1 SEG=C0; pending stays 0.
5. dp_in=2'b10 with value 8'h00 -> digit0 SEG=C0, digit1 SEG=40. With SEG7_LEADING_ZERO_BLANK_EN defined: digit1 SEG=FF, digit0 SEG=C0.
6. Assert rst_n low mid-frame with pending=1 -> SEG=FF and AN=FF immediately (asynchronous). After release the display shows 00 and pending=0.
